// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR sequence generator: FSM states,
// default tap masks and the zero-seed substitution helper.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [31:0] TAPS_32 = 32'hA3000000;
    localparam logic [63:0] TAPS_64 = 64'hD800000000000000;

    // Widest LFSR the seed helper supports; callers zero-extend into it.
    localparam int SEED_MAX_W = 256;

    // An all-zero LFSR locks up, so a zero seed becomes all ones of the given width.
    function automatic logic [SEED_MAX_W-1:0] seed_or_ones(input logic [SEED_MAX_W-1:0] seed,
                                                           input int unsigned width);
        if (seed == '0) return ~({SEED_MAX_W{1'b1}} << width);
        return seed;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR that advances STEP steps per clock through a combinational
// feedback chain; new_bits[STEP-1] is the oldest bit of the clock, new_bits[0] the newest.
module lfsr_core #(
    parameter int                LFSR_W = 32,
    parameter logic [LFSR_W-1:0] TAPS   = 32'hA3000000,
    parameter logic [LFSR_W-1:0] SEED   = '1,
    parameter int                STEP   = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              advance,
    output logic [STEP-1:0]   new_bits
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] chain [0:STEP];
    logic [STEP-1:0]   fb;

    always_comb begin
        fb       = '0;
        new_bits = '0;
        chain[0] = state_q;
        for (int k = 0; k < STEP; k++) begin
            fb[k]              = ^(chain[k] & TAPS);
            chain[k+1]         = {chain[k][LFSR_W-2:0], fb[k]};
            new_bits[STEP-1-k] = fb[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            state_q <= SEED;
        else if (load)
            state_q <= load_val;
        else if (advance)
            state_q <= chain[STEP];
    end

endmodule

// File: rtl/lfsr_seq_gen.sv
// Request-driven LFSR sequence generator with zero padding and valid/ack hold.
// Optional build macro LFSR_SEED_LOAD_EN adds the seed_in/seed_load ports.
//
// state | meaning
// IDLE  | waiting for start; seed may be loaded here
// FILL  | LFSR advancing STEP bits per clock into gen, cnt counts down
// HOLD  | sequence complete, seq_valid high until seq_ack
module lfsr_seq_gen
    import lfsr_pkg::*;
#(
    parameter int                LFSR_W  = 32,
    parameter logic [LFSR_W-1:0] TAPS    = TAPS_32,
    parameter logic [LFSR_W-1:0] SEED    = '1,
    parameter int                SEQ_LEN = 256,
    parameter int                STEP    = 1,
    parameter int                PAD_W   = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     seq_ack,
    output logic [SEQ_LEN+PAD_W-1:0] seq_out,
    output logic                     seq_valid,
    output logic                     busy
`ifdef LFSR_SEED_LOAD_EN
    ,
    input  logic [LFSR_W-1:0]        seed_in,
    input  logic                     seed_load
`endif
);

    localparam int N_CYC = SEQ_LEN / STEP;
    localparam int CNT_W = $clog2(N_CYC + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEQ_LEN-1:0] gen_q, gen_d, gen_shift;
    logic [STEP-1:0]    new_bits;
    logic               advance;
    logic               core_load;
    logic [LFSR_W-1:0]  core_load_val;

`ifdef LFSR_SEED_LOAD_EN
    logic [SEED_MAX_W-1:0] seed_ext;

    always_comb begin
        seed_ext               = '0;
        seed_ext[LFSR_W-1:0]   = seed_in;
    end

    assign core_load     = seed_load && (state_q == IDLE);
    assign core_load_val = LFSR_W'(seed_or_ones(seed_ext, LFSR_W));
`else
    assign core_load     = 1'b0;
    assign core_load_val = '0;
`endif

    lfsr_core #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS),
        .SEED   (SEED),
        .STEP   (STEP)
    ) u_core (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (core_load),
        .load_val (core_load_val),
        .advance  (advance),
        .new_bits (new_bits)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gen_d     = gen_q;
        advance   = 1'b0;
        gen_shift = gen_q << STEP;
        gen_shift[STEP-1:0] = new_bits;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FILL;
                    gen_d   = '0;
                    cnt_d   = CNT_W'(N_CYC);
                end
            end
            FILL: begin
                advance = 1'b1;
                gen_d   = gen_shift;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1))
                    state_d = HOLD;
            end
            HOLD: begin
                if (seq_ack) begin
                    if (start) begin
                        state_d = FILL;
                        gen_d   = '0;
                        cnt_d   = CNT_W'(N_CYC);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gen_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gen_q   <= gen_d;
        end
    end

    always_comb begin
        seq_valid = (state_q == HOLD);
        busy      = (state_q == FILL);
        seq_out   = '0;
        if (seq_valid)
            seq_out[SEQ_LEN+PAD_W-1 -: SEQ_LEN] = gen_q;
    end

endmodule

// File: tb/tb_lfsr_seq_gen.sv
// Self-checking bench for lfsr_seq_gen: a STEP=1 and a STEP=8 instance checked
// against a bit-serial model of the LFSR sequence.
module tb_lfsr_seq_gen;

    localparam int          LW    = 32;
    localparam logic [31:0] TAPS  = 32'hA3000000;
    localparam logic [31:0] SEED  = 32'hFFFF_FFFF;
    localparam int          SEQ   = 256;
    localparam int          PAD   = 32;
    localparam int          OW    = SEQ + PAD;
    localparam int          LIMIT = 1000;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0, seq_ack = 1'b0;
    logic [OW-1:0] seq_out;
    logic          seq_valid, busy;
    logic          start8 = 1'b0, ack8 = 1'b0;
    logic [OW-1:0] seq_out8;
    logic          valid8, busy8;
    logic [LW-1:0] seed_in = '0;
    logic          seed_load = 1'b0;

    int            checks = 0;
    int            errors = 0;
    logic [LW-1:0] model_state;
    logic [OW-1:0] first_run;

    always #5 clk = ~clk;

    lfsr_seq_gen dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .seq_ack   (seq_ack),
        .seq_out   (seq_out),
        .seq_valid (seq_valid),
        .busy      (busy)
`ifdef LFSR_SEED_LOAD_EN
        ,
        .seed_in   (seed_in),
        .seed_load (seed_load)
`endif
    );

    lfsr_seq_gen #(.STEP(8)) dut8 (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start8),
        .seq_ack   (ack8),
        .seq_out   (seq_out8),
        .seq_valid (valid8),
        .busy      (busy8)
`ifdef LFSR_SEED_LOAD_EN
        ,
        .seed_in   ('0),
        .seed_load (1'b0)
`endif
    );

    // Bit i of the request is the i-th LFSR output; it lands at seq_out[OW-1-i].
    function automatic logic [OW-1:0] model_seq(input logic [LW-1:0] st_in,
                                                 output logic [LW-1:0] st_out);
        logic [LW-1:0] st;
        logic [OW-1:0] s;
        logic          b;
        st = st_in;
        s  = '0;
        for (int i = 0; i < SEQ; i++) begin
            b = 1'b0;
            for (int t = 0; t < LW; t++)
                if (TAPS[t]) b = b ^ st[t];
            s[OW-1-i] = b;
            st = {st[LW-2:0], b};
        end
        st_out = st;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start pulse on edge E0, then count edges until seq_valid; noise toggles
    // start and seed_load randomly while the run is in progress.
    task automatic run_seq(input bit noise, output int edges);
        start = 1'b1;
        tick();
        start     = 1'b0;
        seed_load = 1'b0;
        edges     = 1;
        while (!seq_valid && edges < LIMIT) begin
            if (noise) begin
                start     = 1'($urandom_range(0, 1));
                seed_load = 1'($urandom_range(0, 1));
                seed_in   = $urandom;
            end
            tick();
            edges++;
            if (seq_valid) begin
                start     = 1'b0;
                seed_load = 1'b0;
            end
        end
        start     = 1'b0;
        seed_load = 1'b0;
    endtask

    task automatic ack_dut();
        seq_ack = 1'b1;
        tick();
        seq_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        checks++;
        if (seq_out !== '0 || seq_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got out=%h valid=%b busy=%b, want all zero", seq_out, seq_valid, busy);
        end
        checks++;
        if (seq_out8 !== '0 || valid8 !== 1'b0 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs_step8: got out=%h valid=%b busy=%b, want all zero", seq_out8, valid8, busy8);
        end
    endtask

    task automatic test_default_run();
        int            edges;
        logic [OW-1:0] exp;
        model_state = SEED;
        exp = model_seq(model_state, model_state);
        run_seq(1'b0, edges);
        first_run = seq_out;
        checks++;
        if (edges !== SEQ + 1) begin
            errors++;
            $display("FAIL default_latency: got %0d edges, want %0d", edges, SEQ + 1);
        end
        checks++;
        if (seq_out[OW-1:263] !== 25'd0 || seq_out[262] !== 1'b1 || seq_out[PAD-1:0] !== '0) begin
            errors++;
            $display("FAIL default_boundary_bits: got top=%h b262=%b pad=%h, want 0/1/0",
                     seq_out[OW-1:263], seq_out[262], seq_out[PAD-1:0]);
        end
        checks++;
        if (seq_out !== exp) begin
            errors++;
            $display("FAIL default_data: got %h want %h", seq_out, exp);
        end
        checks++;
        if (seq_valid !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL default_flags: got valid=%b busy=%b, want 1/0", seq_valid, busy);
        end
    endtask

    task automatic test_hold();
        logic [OW-1:0] held;
        int            bad;
        held = seq_out;
        bad  = 0;
        for (int i = 0; i < 100; i++) begin
            start = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (seq_out !== held || seq_valid !== 1'b1 || busy !== 1'b0) begin
                errors++;
                bad++;
                if (bad < 4)
                    $display("FAIL hold_stable cycle %0d: got valid=%b busy=%b out=%h, want 1/0/%h",
                             i, seq_valid, busy, seq_out, held);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_back_to_back();
        int            edges;
        logic [OW-1:0] prev, exp;
        prev  = seq_out;
        exp   = model_seq(model_state, model_state);
        start   = 1'b1;
        seq_ack = 1'b1;
        tick();
        start   = 1'b0;
        seq_ack = 1'b0;
        checks++;
        if (seq_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_transition: got valid=%b busy=%b, want 0/1", seq_valid, busy);
        end
        edges = 1;
        while (!seq_valid && edges < LIMIT) begin
            tick();
            edges++;
        end
        checks++;
        if (edges !== SEQ + 1) begin
            errors++;
            $display("FAIL b2b_latency: got %0d edges, want %0d", edges, SEQ + 1);
        end
        checks++;
        if (seq_out !== exp || seq_out === prev) begin
            errors++;
            $display("FAIL b2b_data: got %h want %h", seq_out, exp);
        end
        ack_dut();
        checks++;
        if (seq_valid !== 1'b0 || busy !== 1'b0 || seq_out !== '0) begin
            errors++;
            $display("FAIL ack_to_idle: got valid=%b busy=%b out=%h, want 0/0/0", seq_valid, busy, seq_out);
        end
    endtask

    task automatic test_start_in_fill();
        int            edges;
        logic [OW-1:0] exp;
        exp = model_seq(model_state, model_state);
        run_seq(1'b1, edges);
        checks++;
        if (edges !== SEQ + 1) begin
            errors++;
            $display("FAIL fill_noise_latency: got %0d edges, want %0d", edges, SEQ + 1);
        end
        checks++;
        if (seq_out !== exp) begin
            errors++;
            $display("FAIL fill_noise_data: got %h want %h", seq_out, exp);
        end
        ack_dut();
    endtask

    task automatic test_reset_mid_fill();
        int edges;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat ($urandom_range(10, 200)) tick();
        reset_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (seq_out !== '0 || seq_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midfill_reset_outputs: got out=%h valid=%b busy=%b, want all zero", seq_out, seq_valid, busy);
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if (seq_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midfill_release: got valid=%b busy=%b, want 0/0", seq_valid, busy);
        end
        model_state = SEED;
        run_seq(1'b0, edges);
        checks++;
        if (seq_out !== first_run || edges !== SEQ + 1) begin
            errors++;
            $display("FAIL midfill_rerun: got %h (%0d edges) want %h (%0d edges)", seq_out, edges, first_run, SEQ + 1);
        end
        ack_dut();
    endtask

    task automatic test_step8();
        int            edges;
        logic [LW-1:0] st;
        logic [OW-1:0] exp1, exp2;
        st   = SEED;
        exp1 = model_seq(st, st);
        exp2 = model_seq(st, st);
        for (int r = 0; r < 2; r++) begin
            start8 = 1'b1;
            if (r == 1) ack8 = 1'b1;
            tick();
            start8 = 1'b0;
            ack8   = 1'b0;
            edges  = 1;
            while (!valid8 && edges < LIMIT) begin
                tick();
                edges++;
            end
            checks++;
            if (edges !== SEQ / 8 + 1) begin
                errors++;
                $display("FAIL step8_latency run %0d: got %0d edges, want %0d", r, edges, SEQ / 8 + 1);
            end
            checks++;
            if (seq_out8 !== (r == 0 ? exp1 : exp2)) begin
                errors++;
                $display("FAIL step8_data run %0d: got %h want %h", r, seq_out8, (r == 0 ? exp1 : exp2));
            end
        end
        ack8 = 1'b1;
        tick();
        ack8 = 1'b0;
    endtask

`ifdef LFSR_SEED_LOAD_EN
    task automatic test_seed_load();
        int            edges;
        logic [LW-1:0] st;
        logic [OW-1:0] exp;
        seed_in   = '0;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        st  = '1;
        exp = model_seq(st, st);
        run_seq(1'b0, edges);
        checks++;
        if (seq_out !== exp) begin
            errors++;
            $display("FAIL seed_zero_load: got %h want %h", seq_out, exp);
        end
        ack_dut();
        seed_in   = 32'h1;
        seed_load = 1'b1;
        st  = 32'h1;
        exp = model_seq(st, st);
        run_seq(1'b1, edges);
        checks++;
        if (seq_out !== exp || edges !== SEQ + 1) begin
            errors++;
            $display("FAIL seed_one_with_start: got %h (%0d edges) want %h", seq_out, edges, exp);
        end
        ack_dut();
    endtask
`endif

    initial begin
        test_reset();
        test_default_run();
        test_hold();
        test_back_to_back();
        test_start_in_fill();
        test_reset_mid_fill();
        test_step8();
`ifdef LFSR_SEED_LOAD_EN
        test_seed_load();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
